// File: rtl/bram_pkg.sv
// Shared types and helpers for the bram_sdp family.
package bram_pkg;

  typedef enum logic {
    RD_FIRST = 1'b0,
    WR_FIRST = 1'b1
  } rw_mode_e;

  // Widest word the byte-merge helper handles; callers cast to and from it.
  localparam int unsigned MAX_DATA_W = 1024;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  // Address width for a given depth, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic logic [MAX_DATA_W-1:0] merge_be(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] m;
    m = old_w;
    for (int i = 0; i < int'(MAX_BE_W); i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read output pipeline: RD_LAT register stages carrying data, valid and
// collision (and parity error when BRAM_SDP_PARITY_EN is defined).
// Data holds its last value while no valid word passes a stage.
module bram_rd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_coll,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_coll
`ifdef BRAM_SDP_PARITY_EN
  , input  logic            i_perr
  , output logic            o_perr
`endif
);

  logic              r_valid [RD_LAT];
  logic [DATA_W-1:0] r_data  [RD_LAT];
  logic              r_coll  [RD_LAT];
`ifdef BRAM_SDP_PARITY_EN
  logic              r_perr  [RD_LAT];
`endif

  // Stage registers; flags are qualified by valid, data only loads on valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < int'(RD_LAT); s++) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
        r_coll[s]  <= 1'b0;
`ifdef BRAM_SDP_PARITY_EN
        r_perr[s]  <= 1'b0;
`endif
      end
    end else begin
      r_valid[0] <= i_valid;
      r_coll[0]  <= i_valid & i_coll;
`ifdef BRAM_SDP_PARITY_EN
      r_perr[0]  <= i_valid & i_perr;
`endif
      if (i_valid) r_data[0] <= i_data;
      for (int s = 1; s < int'(RD_LAT); s++) begin
        r_valid[s] <= r_valid[s-1];
        r_coll[s]  <= r_coll[s-1];
`ifdef BRAM_SDP_PARITY_EN
        r_perr[s]  <= r_perr[s-1];
`endif
        if (r_valid[s-1]) r_data[s] <= r_data[s-1];
      end
    end
  end

  assign o_valid = r_valid[RD_LAT-1];
  assign o_data  = r_data[RD_LAT-1];
  assign o_coll  = r_coll[RD_LAT-1];
`ifdef BRAM_SDP_PARITY_EN
  assign o_perr  = r_perr[RD_LAT-1];
`endif

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port block RAM with byte enables, RD_LAT of 1 or 2, selectable
// same-address read-during-write policy and collision reporting.
// Optional per-byte even parity with error flag: define BRAM_SDP_PARITY_EN.
module bram_sdp
  import bram_pkg::*;
#(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned DEPTH   = 256,
  parameter  int unsigned RD_LAT  = 1,
  parameter  int unsigned RW_MODE = 0,
  localparam int unsigned ADDR_W  = addr_w(DEPTH),
  localparam int unsigned BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              collision
`ifdef BRAM_SDP_PARITY_EN
  , input  logic            perr_inject
  , output logic            rd_perr
`endif
);

  localparam bit WR_FIRST_MODE = (RW_MODE == 32'(WR_FIRST));

  // Elaboration-time parameter checks.
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $fatal(1, "bram_sdp: RD_LAT must be 1 or 2");
  end
  if ((DATA_W % 8) != 0 || DATA_W == 0 || DATA_W > MAX_DATA_W) begin : g_bad_w
    $fatal(1, "bram_sdp: DATA_W must be a non-zero multiple of 8");
  end
  if (DEPTH == 0) begin : g_bad_depth
    $fatal(1, "bram_sdp: DEPTH must be non-zero");
  end
  if (RW_MODE > 1) begin : g_bad_mode
    $fatal(1, "bram_sdp: RW_MODE must be 0 or 1");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_coll;
  logic [DATA_W-1:0] w_rd_word;

  assign w_wr_ok = wr_en && (32'(wr_addr) < DEPTH);
  assign w_rd_ok = rd_en && (32'(rd_addr) < DEPTH);
  assign w_coll  = w_wr_ok && w_rd_ok && (wr_addr == rd_addr);

  // Byte-masked array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (wr_be[b]) r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Array read with write-first bypass; out-of-range reads return zero.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_ok) begin
      w_rd_word = r_mem[rd_addr];
      if (WR_FIRST_MODE && w_coll) begin
        w_rd_word = DATA_W'(merge_be(MAX_DATA_W'(r_mem[rd_addr]),
                                     MAX_DATA_W'(wr_data),
                                     MAX_BE_W'(wr_be)));
      end
    end
  end

`ifdef BRAM_SDP_PARITY_EN
  logic [BE_W-1:0] r_par [DEPTH];
  logic [BE_W-1:0] w_wr_par;
  logic [BE_W-1:0] w_rd_par;
  logic [BE_W-1:0] w_calc_par;
  logic            w_perr;

  // Even parity of each incoming byte, optionally corrupted by the test hook.
  always_comb begin
    w_wr_par = '0;
    for (int b = 0; b < int'(BE_W); b++) begin
      w_wr_par[b] = (^wr_data[8*b +: 8]) ^ perr_inject;
    end
  end

  // Parity store, written under the same byte enables as the data.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (wr_be[b]) r_par[wr_addr][b] <= w_wr_par[b];
      end
    end
  end

  // Compare stored parity with parity recomputed from the returned word.
  always_comb begin
    w_rd_par   = '0;
    w_calc_par = '0;
    w_perr     = 1'b0;
    if (w_rd_ok) begin
      w_rd_par = r_par[rd_addr];
      if (WR_FIRST_MODE && w_coll) begin
        for (int b = 0; b < int'(BE_W); b++) begin
          if (wr_be[b]) w_rd_par[b] = w_wr_par[b];
        end
      end
      for (int b = 0; b < int'(BE_W); b++) begin
        w_calc_par[b] = ^w_rd_word[8*b +: 8];
      end
      w_perr = (w_calc_par != w_rd_par);
    end
  end
`endif

  bram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (rd_en),
    .i_data  (w_rd_word),
    .i_coll  (w_coll),
    .o_valid (rd_valid),
    .o_data  (rd_data),
    .o_coll  (collision)
`ifdef BRAM_SDP_PARITY_EN
    , .i_perr (w_perr)
    , .o_perr (rd_perr)
`endif
  );

endmodule

// File: tb/tb_bram_sdp.sv
// Directed bench for bram_sdp: three instances (RD_LAT=1 read-first,
// RD_LAT=1 write-first, RD_LAT=2 DEPTH=10 read-first) share one stimulus.
module tb_bram_sdp;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [31:0] d0_data, d1_data, d2_data;
  logic        d0_valid, d1_valid, d2_valid;
  logic        d0_coll, d1_coll, d2_coll;
`ifdef BRAM_SDP_PARITY_EN
  logic        perr_inject;
  logic        d0_perr, d1_perr, d2_perr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_sdp #(.DATA_W(32), .DEPTH(16), .RD_LAT(1), .RW_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d0_data), .rd_valid(d0_valid), .collision(d0_coll)
`ifdef BRAM_SDP_PARITY_EN
    , .perr_inject(perr_inject), .rd_perr(d0_perr)
`endif
  );

  bram_sdp #(.DATA_W(32), .DEPTH(16), .RD_LAT(1), .RW_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d1_data), .rd_valid(d1_valid), .collision(d1_coll)
`ifdef BRAM_SDP_PARITY_EN
    , .perr_inject(perr_inject), .rd_perr(d1_perr)
`endif
  );

  bram_sdp #(.DATA_W(32), .DEPTH(10), .RD_LAT(2), .RW_MODE(0)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d2_data), .rd_valid(d2_valid), .collision(d2_coll)
`ifdef BRAM_SDP_PARITY_EN
    , .perr_inject(perr_inject), .rd_perr(d2_perr)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0; wr_be = 4'h0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = 4'h0; wr_data = 32'h0; wr_be = 4'h0;
    rd_en = 1'b0; rd_addr = 4'h0;
`ifdef BRAM_SDP_PARITY_EN
    perr_inject = 1'b0;
`endif
    tick(); tick();
    checks++; if (d0_valid !== 1'b0) begin failures++; $display("FAIL rst_d0_valid got=%b exp=0", d0_valid); end
    checks++; if (d0_data !== 32'h0) begin failures++; $display("FAIL rst_d0_data got=%h exp=0", d0_data); end
    checks++; if (d0_coll !== 1'b0) begin failures++; $display("FAIL rst_d0_coll got=%b exp=0", d0_coll); end
    checks++; if (d2_valid !== 1'b0 || d2_data !== 32'h0 || d2_coll !== 1'b0) begin
      failures++; $display("FAIL rst_d2 got v=%b d=%h c=%b exp v=0 d=0 c=0", d2_valid, d2_data, d2_coll); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    checks++; if (d0_valid !== 1'b0) begin failures++; $display("FAIL wr_only_valid got=%b exp=0", d0_valid); end
    rd(4'd3);
    checks++; if (d0_valid !== 1'b1) begin failures++; $display("FAIL rd_d0_valid got=%b exp=1", d0_valid); end
    checks++; if (d0_data !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_d0_data got=%h exp=deadbeef", d0_data); end
    checks++; if (d0_coll !== 1'b0) begin failures++; $display("FAIL rd_d0_coll got=%b exp=0", d0_coll); end
    checks++; if (d2_valid !== 1'b0) begin failures++; $display("FAIL rd_d2_early got=%b exp=0", d2_valid); end
    tick();
    checks++; if (d0_valid !== 1'b0 || d0_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_d0_hold got v=%b d=%h exp v=0 d=deadbeef", d0_valid, d0_data); end
    checks++; if (d2_valid !== 1'b1 || d2_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_d2_lat2 got v=%b d=%h exp v=1 d=deadbeef", d2_valid, d2_data); end
  endtask

  task automatic test_byte_enable();
    wr(4'd5, 32'h11223344, 4'hF);
    wr(4'd5, 32'hAABBCCDD, 4'b0101);
    rd(4'd5);
    checks++; if (d0_data !== 32'h11BB33DD) begin failures++; $display("FAIL be_merge got=%h exp=11bb33dd", d0_data); end
    wr(4'd5, 32'h00000000, 4'h0);
    rd(4'd5);
    checks++; if (d1_data !== 32'h11BB33DD) begin failures++; $display("FAIL be_zero_noop got=%h exp=11bb33dd", d1_data); end
  endtask

  task automatic test_collision();
    wr(4'd7, 32'h00000000, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h12345678; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    wr_en = 1'b0; wr_be = 4'h0; rd_en = 1'b0;
    checks++; if (d0_valid !== 1'b1 || d0_data !== 32'h0) begin
      failures++; $display("FAIL coll_rdfirst got v=%b d=%h exp v=1 d=0", d0_valid, d0_data); end
    checks++; if (d0_coll !== 1'b1) begin failures++; $display("FAIL coll_d0_flag got=%b exp=1", d0_coll); end
    checks++; if (d1_valid !== 1'b1 || d1_data !== 32'h12345678) begin
      failures++; $display("FAIL coll_wrfirst got v=%b d=%h exp v=1 d=12345678", d1_valid, d1_data); end
    checks++; if (d1_coll !== 1'b1) begin failures++; $display("FAIL coll_d1_flag got=%b exp=1", d1_coll); end
    checks++; if (d2_coll !== 1'b0) begin failures++; $display("FAIL coll_d2_early got=%b exp=0", d2_coll); end
    tick();
    checks++; if (d0_coll !== 1'b0) begin failures++; $display("FAIL coll_pulse_end got=%b exp=0", d0_coll); end
    checks++; if (d2_valid !== 1'b1 || d2_data !== 32'h0 || d2_coll !== 1'b1) begin
      failures++; $display("FAIL coll_d2 got v=%b d=%h c=%b exp v=1 d=0 c=1", d2_valid, d2_data, d2_coll); end
    rd(4'd7);
    checks++; if (d0_data !== 32'h12345678) begin failures++; $display("FAIL coll_written got=%h exp=12345678", d0_data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) wr(4'(i), 32'hA5A50000 + 32'(i), 4'hF);
    rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    checks++; if (d0_valid !== 1'b1 || d0_data !== 32'hA5A50000) begin
      failures++; $display("FAIL b2b_d0_0 got v=%b d=%h exp v=1 d=a5a50000", d0_valid, d0_data); end
    checks++; if (d2_valid !== 1'b0) begin failures++; $display("FAIL b2b_d2_early got=%b exp=0", d2_valid); end
    rd_addr = 4'd1;
    tick();
    checks++; if (d0_data !== 32'hA5A50001) begin failures++; $display("FAIL b2b_d0_1 got=%h exp=a5a50001", d0_data); end
    checks++; if (d2_valid !== 1'b1 || d2_data !== 32'hA5A50000) begin
      failures++; $display("FAIL b2b_d2_0 got v=%b d=%h exp v=1 d=a5a50000", d2_valid, d2_data); end
    rd_addr = 4'd2;
    tick();
    rd_en = 1'b0;
    checks++; if (d2_valid !== 1'b1 || d2_data !== 32'hA5A50001) begin
      failures++; $display("FAIL b2b_d2_1 got v=%b d=%h exp v=1 d=a5a50001", d2_valid, d2_data); end
    tick();
    checks++; if (d2_valid !== 1'b1 || d2_data !== 32'hA5A50002) begin
      failures++; $display("FAIL b2b_d2_2 got v=%b d=%h exp v=1 d=a5a50002", d2_valid, d2_data); end
    tick();
    checks++; if (d2_valid !== 1'b0 || d2_data !== 32'hA5A50002) begin
      failures++; $display("FAIL b2b_d2_end got v=%b d=%h exp v=0 d=a5a50002", d2_valid, d2_data); end
  endtask

  task automatic test_out_of_range();
    wr(4'd12, 32'hFFFFFFFF, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd12;
    tick();
    wr_en = 1'b0; wr_be = 4'h0; rd_en = 1'b0;
    tick();
    checks++; if (d2_valid !== 1'b1 || d2_data !== 32'h0) begin
      failures++; $display("FAIL oor_read got v=%b d=%h exp v=1 d=0", d2_valid, d2_data); end
    checks++; if (d2_coll !== 1'b0) begin failures++; $display("FAIL oor_coll got=%b exp=0", d2_coll); end
    for (int i = 0; i < 10; i++) begin
      rd(4'(i));
      tick();
      checks++; if (d2_data !== 32'hA5A50000 + 32'(i)) begin
        failures++; $display("FAIL oor_unchanged_%0d got=%h exp=%h", i, d2_data, 32'hA5A50000 + 32'(i)); end
    end
  endtask

  task automatic test_reset_inflight();
    wr(4'd3, 32'hCAFEF00D, 4'hF);
    rd(4'd3);
    reset = 1'b1;
    #1;
    checks++; if (d0_valid !== 1'b0 || d2_valid !== 1'b0) begin
      failures++; $display("FAIL mid_rst_clear got d0v=%b d2v=%b exp 0 0", d0_valid, d2_valid); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (d2_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_discard_%0d got=%b exp=0", i, d2_valid); end
    end
    rd(4'd3);
    checks++; if (d0_valid !== 1'b1 || d0_data !== 32'hCAFEF00D) begin
      failures++; $display("FAIL post_rst_d0 got v=%b d=%h exp v=1 d=cafef00d", d0_valid, d0_data); end
    tick();
    checks++; if (d2_valid !== 1'b1 || d2_data !== 32'hCAFEF00D) begin
      failures++; $display("FAIL post_rst_d2 got v=%b d=%h exp v=1 d=cafef00d", d2_valid, d2_data); end
  endtask

`ifdef BRAM_SDP_PARITY_EN
  task automatic test_parity();
    perr_inject = 1'b1;
    wr(4'd2, 32'h5A5A5A5A, 4'hF);
    perr_inject = 1'b0;
    rd(4'd2);
    checks++; if (d0_perr !== 1'b1) begin failures++; $display("FAIL perr_inject got=%b exp=1", d0_perr); end
    tick();
    checks++; if (d2_perr !== 1'b1) begin failures++; $display("FAIL perr_inject_d2 got=%b exp=1", d2_perr); end
    wr(4'd2, 32'h5A5A5A5A, 4'hF);
    rd(4'd2);
    checks++; if (d0_perr !== 1'b0) begin failures++; $display("FAIL perr_clean got=%b exp=0", d0_perr); end
    rd(4'd12);
    checks++; if (d0_perr !== 1'b0) begin failures++; $display("FAIL perr_d0_a12 got=%b exp=0", d0_perr); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_reset_inflight();
`ifdef BRAM_SDP_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_sdp.md
Name: bram_sdp

Overview:
Parametrised simple-dual-port block RAM: one write port, one read port, one clock domain. Adds per-byte write enables, a configurable read latency with a valid strobe, a selectable read-during-write policy and same-address collision reporting. Used as the storage primitive under datapath buffers and the bench's memory model. It is the generalised successor of the fixed-size bram.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
DEPTH, 256, number of words; need not be a power of two.
RD_LAT, 1, read latency in cycles; legal values are 1 and 2.
RW_MODE, 0, same-address read-during-write policy: 0 = read-first (old data), 1 = write-first (new data).

Ports:
clk  in  1  clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-high reset.
wr_en  in  1  write strobe.
wr_addr  in  ADDR_W  write address; ADDR_W = max(1, clog2(DEPTH)).
wr_data  in  DATA_W  write data.
wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
rd_en  in  1  read request.
rd_addr  in  ADDR_W  read address.
rd_data  out  DATA_W  read data; valid when rd_valid=1.
rd_valid  out  1  rd_data qualifier.
collision  out  1  one-cycle pulse for a same-address read and write.

Behaviour:
- Reset (async, active-high): rd_data=0, rd_valid=0, collision=0, all pipeline stages cleared. Memory array is not cleared; contents survive reset.
- Write: on a rising edge with wr_en=1 and wr_addr<DEPTH, bytes with wr_be[i]=1 are updated. Other bytes keep their value. wr_be=0 is a no-op.
- Read: rd_en=1 at edge N gives rd_valid=1 and rd_data at edge N+RD_LAT.
- Back-to-back reads are allowed every cycle; throughput is 1 per cycle with no stall input.
- While rd_valid=0, rd_data holds its last value.
- RD_LAT=2 adds one output register stage after the array read; data and valid advance together.
- Same-address collision: wr_en=1, rd_en=1, wr_addr==rd_addr<DEPTH in the same cycle.
  - collision pulses in the same cycle the read result appears.
  - RW_MODE=0: the read returns pre-write contents.
  - RW_MODE=1: the read returns the merged word (new bytes where wr_be=1, old bytes elsewhere).
- Out of range (addr>=DEPTH): the write is dropped. The read still produces rd_valid with rd_data=0, and collision is not asserted.
- Reset mid-operation: in-flight reads are discarded, and rd_valid stays 0 until a new rd_en is seen after reset deasserts.
- Illegal RD_LAT or DATA_W%8!=0: elaboration-time $fatal.

Optional Feature:
- Macro: BRAM_SDP_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte, written alongside the byte under wr_be.
  - Extra output port rd_perr (width 1, reset 0) is aligned with rd_valid. It is 1 if any byte's recomputed parity mismatches.
  - Out-of-range reads give rd_perr=0.
  - A test hook input perr_inject (width 1) flips the stored parity of every written byte in that cycle.
- Undefined: no parity storage, and neither rd_perr nor perr_inject exists.

Decomposition:
- bram_pkg holds:
  - the rw_mode_e enum (RD_FIRST=0, WR_FIRST=1);
  - the addr_w(depth) function;
  - the byte-merge function merge_be(old, new, be).
- Sub-module bram_rd_pipe: RD_LAT-stage data/valid/collision(/perr) output pipeline with async reset. The array and write logic stay in bram_sdp.

Test Plan:
1. DATA_W=32, DEPTH=16, RD_LAT=1. Reset, write 0xDEADBEEF to addr 3 with be=4'hF, then read addr 3 -> rd_valid one cycle after rd_en, rd_data=0xDEADBEEF, collision=0.
2. Addr 5 holds 0x11223344. Write 0xAABBCCDD to addr 5 with be=4'b0101 -> subsequent read of addr 5 returns 0x11BB33DD.
3. Addr 7 holds 0x0. Same-cycle write of 0x12345678 (be=F) and read of addr 7 -> RW_MODE=0 returns 0x00000000, RW_MODE=1 returns 0x12345678; collision=1 in both, aligned with rd_valid.
4. RD_LAT=2, DEPTH=10. Reads of addrs 0,1,2 on consecutive cycles -> three consecutive rd_valid cycles starting 2 cycles after the first rd_en. Write 0xFFFFFFFF to addr 12, then read addr 12 -> rd_data=0, and addrs 0..9 are unchanged.
5. Issue rd_en to addr 3 (holding 0xCAFEF00D), then assert reset for one cycle before the result emerges -> rd_valid never asserts for that read. After release, a read of addr 3 returns 0xCAFEF00D.
6. With BRAM_SDP_PARITY_EN defined: write addr 2 with perr_inject=1, then read addr 2 -> rd_perr=1. Write addr 2 normally, then read -> rd_perr=0.
